data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Load/store front-end between the core's memory stage and the same-cycle-read BSRAM data array.
- Accepts byte/half/word requests on a byte address and performs sign/zero-extended loads.
- Sub-word stores are done as a two-cycle read-modify-write because the array has only word writes.
- Flags misaligned accesses without touching memory.

Parameters:
- CORE, 0, core index (carried for debug reporting).
- DATA_WIDTH, 32, word width; the block is only defined for 32.
- ADDR_WIDTH, 8, word-address width of the attached BSRAM. The byte address is ADDR_WIDTH+2 bits.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_data  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal-size request.
- mem_readEnable  out  1  to BSRAM.
- mem_readAddress  out  ADDR_WIDTH  to BSRAM.
- mem_readData  in  32  from BSRAM, same-cycle.
- mem_writeEnable  out  1  to BSRAM.
- mem_writeAddress  out  ADDR_WIDTH  to BSRAM.
- mem_writeData  out  32  to BSRAM.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is named clock, reset port is named reset.
- Reset values: state IDLE; resp_valid = 0; resp_data = 0; resp_error = 0; mem_readEnable = 0; mem_writeEnable = 0; captured request registers = 0.
- req_ready = 1 in IDLE and RESP, 0 in ACCESS and WRITE.
- A request is accepted when req_valid & req_ready. All req_* fields are latched and the state goes to ACCESS.
- States: IDLE, ACCESS, WRITE, RESP.
- ACCESS, error check first:
  - Error when size==3, or half with addr[0]=1, or word with addr[1:0]!=0.
  - On error: no memory enable is asserted; go to RESP with resp_error=1 and resp_data=0.
- ACCESS, load:
  - mem_readEnable=1, mem_readAddress=addr[ADDR_WIDTH+1:2].
  - Select the lane (byte by addr[1:0], half by addr[1]), extend per unsigned, register into resp_data; go to RESP.
- ACCESS, word store: mem_writeEnable=1 with req_wdata, readEnable=0; go to RESP.
- ACCESS, sub-word store (read phase):
  - mem_readEnable=1.
  - Register the merged word: old word with the target lane replaced by wdata[7:0] or wdata[15:0].
  - Go to WRITE.
- WRITE:
  - mem_writeEnable=1 with the merged word; mem_readEnable=0.
  - readEnable must be 0 here: the array's read/write bypass would otherwise form a combinational loop if read and write ran in the same cycle.
  - Go to RESP.
- RESP:
  - resp_valid=1 for exactly this cycle.
  - If a new request is accepted, go to ACCESS; otherwise go to IDLE.
  - resp_data and resp_error hold until the next response.
- Memory enables are decoded combinationally from the state, so an asserted reset drops them immediately.
- Latency from the accept edge to the resp_valid cycle:
  - load, word store, error: 2 cycles.
  - sub-word store: 3 cycles.
- Back-to-back requests accepted in RESP: throughput is one load per 2 cycles.
- Reset mid-operation:
  - The request is discarded and no response is produced.
  - A WRITE-state write is not committed unless its clock edge occurs before reset asserts.
- Address wrap: the word index uses only addr[ADDR_WIDTH+1:2]; there are no out-of-range checks.

Decomposition:
- Package data_mem_pkg:
  - size codes SIZE_B=0, SIZE_H=1, SIZE_W=2;
  - state encoding IDLE/ACCESS/WRITE/RESP;
  - lane-mask constants.
- Sub-module mem_lane_align: purely combinational. It provides load extract/extend and store lane merge, is reused for both paths, and is unit-testable in isolation.

Test Plan:
- Memory word 5 = 0x80F1_7F02. Load byte addr 0x15, signed -> resp_data 0x0000_007F. Addr 0x16 signed -> 0xFFFF_FFF1. Addr 0x16 unsigned -> 0x0000_00F1. Each response arrives 2 cycles after accept.
- Load half addr 0x16, signed, word 0x80F1_7F02 -> 0xFFFF_80F1. Same load, unsigned -> 0x0000_80F1.
- Store byte 0xAB to addr 0x21, word 8 = 0x1122_3344:
  - cycle 1: readEnable=1, writeEnable=0;
  - cycle 2: writeEnable=1, readEnable=0, writeData 0x1122_AB44;
  - resp_valid in cycle 3; a subsequent load returns 0x1122_AB44.
- Misaligned word load addr 0x02, half store addr 0x03, and size=3 -> resp_error=1, resp_data=0, both mem enables stay 0 throughout.
- Back-to-back: word store 0xDEAD_BEEF to 0x40 accepted in IDLE, then load word 0x40 accepted during the RESP cycle -> second resp_valid 2 cycles later with 0xDEAD_BEEF.
- Assert reset while in WRITE (async, mid-cycle) -> mem_writeEnable drops immediately, target word unchanged, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory load/store front-end.
// Size codes, controller states, lane masks and the access legality rule.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_t;

  localparam logic [31:0] BYTE_LANE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_LANE_MASK = 32'h0000_FFFF;

  // Illegal size code or an address not aligned to the access size.
  function automatic logic isBadAccess(size_t size, logic [1:0] addrLow);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addrLow[0];
      SIZE_W:  return addrLow != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
// Shared by the load path and the read-modify-write store path.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] wdata,
  input  logic [1:0]  addrLow,
  input  size_t       size,
  input  logic        isUnsigned,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);

  logic [4:0]  shift;
  logic [31:0] laneMask;
  logic [15:0] loadHalf;
  logic [7:0]  loadByte;

  assign shift    = {addrLow, 3'b000};
  assign loadHalf = 16'(oldWord >> shift);
  assign loadByte = loadHalf[7:0];

  always_comb begin
    loadData = oldWord;
    laneMask = '1;
    case (size)
      SIZE_B: begin
        loadData = isUnsigned ? {24'b0, loadByte} : {{24{loadByte[7]}}, loadByte};
        laneMask = BYTE_LANE_MASK << shift;
      end
      SIZE_H: begin
        loadData = isUnsigned ? {16'b0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
        laneMask = HALF_LANE_MASK << shift;
      end
      default: ;
    endcase
  end

  assign mergedWord = (oldWord & ~laneMask) | ((wdata << shift) & laneMask);

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store front-end between the memory stage and a same-cycle-read BSRAM.
// Sub-word stores are a two-cycle read-modify-write; misaligned requests never touch memory.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_error,
  output logic                  mem_readEnable,
  output logic [ADDR_WIDTH-1:0] mem_readAddress,
  input  logic [DATA_WIDTH-1:0] mem_readData,
  output logic                  mem_writeEnable,
  output logic [ADDR_WIDTH-1:0] mem_writeAddress,
  output logic [DATA_WIDTH-1:0] mem_writeData
);

  // CORE is carried for debug reporting only; only 32-bit words are defined.
  if (DATA_WIDTH != 32 || CORE < 0) begin : gUnsupported
    $error("data_mem_ctrl: DATA_WIDTH must be 32");
  end

  state_t                state, stateNext;
  logic                  reqWrite, reqUnsigned;
  size_t                 reqSize;
  logic [ADDR_WIDTH+1:0] reqAddr;
  logic [DATA_WIDTH-1:0] reqWdata, mergedReg;
  logic [DATA_WIDTH-1:0] loadData, mergeData, respDataNext;
  logic                  accept, badAccess, captureResp, captureMerge, respErrorNext;

  assign req_ready        = (state == IDLE) || (state == RESP);
  assign accept           = req_valid && req_ready;
  assign resp_valid       = (state == RESP);
  assign badAccess        = isBadAccess(reqSize, reqAddr[1:0]);
  assign mem_readAddress  = reqAddr[ADDR_WIDTH+1:2];
  assign mem_writeAddress = reqAddr[ADDR_WIDTH+1:2];

  mem_lane_align uAlign (
    .oldWord    (mem_readData),
    .wdata      (reqWdata),
    .addrLow    (reqAddr[1:0]),
    .size       (reqSize),
    .isUnsigned (reqUnsigned),
    .loadData   (loadData),
    .mergedWord (mergeData)
  );

  // Enables decode from state alone so an asserting reset drops them at once.
  always_comb begin
    stateNext       = state;
    mem_readEnable  = 1'b0;
    mem_writeEnable = 1'b0;
    mem_writeData   = reqWdata;
    captureResp     = 1'b0;
    captureMerge    = 1'b0;
    respDataNext    = '0;
    respErrorNext   = 1'b0;
    case (state)
      IDLE: if (accept) stateNext = ACCESS;
      ACCESS: begin
        if (badAccess) begin
          captureResp   = 1'b1;
          respErrorNext = 1'b1;
          stateNext     = RESP;
        end else if (!reqWrite) begin
          mem_readEnable = 1'b1;
          captureResp    = 1'b1;
          respDataNext   = loadData;
          stateNext      = RESP;
        end else if (reqSize == SIZE_W) begin
          mem_writeEnable = 1'b1;
          captureResp     = 1'b1;
          stateNext       = RESP;
        end else begin
          mem_readEnable = 1'b1;
          captureMerge   = 1'b1;
          stateNext      = WRITE;
        end
      end
      // No read here: the array's read/write bypass would close a loop.
      WRITE: begin
        mem_writeEnable = 1'b1;
        mem_writeData   = mergedReg;
        captureResp     = 1'b1;
        stateNext       = RESP;
      end
      RESP:    stateNext = accept ? ACCESS : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      reqWrite    <= 1'b0;
      reqSize     <= SIZE_B;
      reqUnsigned <= 1'b0;
      reqAddr     <= '0;
      reqWdata    <= '0;
      mergedReg   <= '0;
      resp_data   <= '0;
      resp_error  <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        reqWrite    <= req_write;
        reqSize     <= size_t'(req_size);
        reqUnsigned <= req_unsigned;
        reqAddr     <= req_addr;
        reqWdata    <= req_wdata;
      end
      if (captureMerge) mergedReg <= mergeData;
      if (captureResp) begin
        resp_data  <= respDataNext;
        resp_error <= respErrorNext;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized
// traffic checked against a byte-level reference memory model.
module tb_data_mem_ctrl;

  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]    req_size = '0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid, resp_error;
  logic [31:0]   resp_data;
  logic          mem_readEnable, mem_writeEnable;
  logic [AW-1:0] mem_readAddress, mem_writeAddress;
  logic [31:0]   mem_readData, mem_writeData;

  int checks = 0;
  int errors = 0;

  logic [31:0] bram   [256];
  logic [31:0] refMem [256];

  always #5 clock = ~clock;

  assign mem_readData = bram[mem_readAddress];
  always @(posedge clock) if (mem_writeEnable) bram[mem_writeAddress] = mem_writeData;

  data_mem_ctrl #(.CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .mem_readEnable(mem_readEnable), .mem_readAddress(mem_readAddress),
    .mem_readData(mem_readData),
    .mem_writeEnable(mem_writeEnable), .mem_writeAddress(mem_writeAddress),
    .mem_writeData(mem_writeData)
  );

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic logic refErr(logic [1:0] sz, logic [9:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] refLoad(logic [31:0] w, logic [9:0] a, logic [1:0] sz, logic u);
    longint v;
    int unsigned sh;
    sh = 8 * int'(a[1:0]);
    if (sz == 2'd0) begin
      v = longint'((w >> sh) % 256);
      if (!u && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = longint'((w >> sh) % 65536);
      if (!u && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] refStore(logic [31:0] w, logic [9:0] a, logic [1:0] sz, logic [31:0] d);
    logic [7:0] b [4];
    int unsigned k;
    if (sz == 2'd2) return d;
    for (int unsigned i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    k = int'(a[1:0]);
    b[k] = d[7:0];
    if (sz == 2'd1) b[k+1] = d[15:8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic setWord(input int unsigned idx, input logic [31:0] v);
    bram[idx]   = v;
    refMem[idx] = v;
  endtask

  // Drives one request and records per-cycle bus activity until the response.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [9:0] a,
                       input logic [31:0] wd, output int lat, output logic [31:0] data,
                       output logic err, output logic [7:0] rdSeen, output logic [7:0] wrSeen,
                       output logic [31:0] wdSeen);
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0; data = 'x; err = 1'bx; rdSeen = '0; wrSeen = '0; wdSeen = '0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clock);
      rdSeen[c] = mem_readEnable;
      wrSeen[c] = mem_writeEnable;
      if (mem_writeEnable) wdSeen = mem_writeData;
      if (resp_valid) begin
        lat = c; data = resp_data; err = resp_error;
        break;
      end
    end
  endtask

  // ---------------------------------- tests ---------------------------------
  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({resp_valid, resp_error, mem_readEnable, mem_writeEnable, req_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags got valid/err/rd/wr/ready=%b expected 00001",
               {resp_valid, resp_error, mem_readEnable, mem_writeEnable, req_ready});
    end
    checks++;
    if (resp_data !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h expected 00000000", resp_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_loads();
    logic [9:0]  addrs [5] = '{10'h15, 10'h16, 10'h16, 10'h16, 10'h16};
    logic [1:0]  sizes [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    logic        unss  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exps  [5] = '{32'h0000_007F, 32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_80F1, 32'h0000_80F1};
    int lat; logic [31:0] d, wds; logic e; logic [7:0] rd, wr;
    setWord(5, 32'h80F1_7F02);
    for (int unsigned i = 0; i < 5; i++) begin
      issue(1'b0, sizes[i], unss[i], addrs[i], 32'h0, lat, d, e, rd, wr, wds);
      checks++;
      if (d !== exps[i] || e !== 1'b0) begin
        errors++; $display("FAIL load_%0d got data=%h err=%b expected %h err=0", i, d, e, exps[i]);
      end
      checks++;
      if (lat != 2) begin
        errors++; $display("FAIL load_latency_%0d got %0d expected 2", i, lat);
      end
    end
  endtask

  task automatic test_subword_store();
    int lat; logic [31:0] d, wds; logic e; logic [7:0] rd, wr;
    setWord(8, 32'h1122_3344);
    issue(1'b1, 2'd0, 1'b0, 10'h21, 32'h0000_00AB, lat, d, e, rd, wr, wds);
    refMem[8] = refStore(refMem[8], 10'h21, 2'd0, 32'hAB);
    checks++;
    if ({rd[1], wr[1], rd[2], wr[2]} !== 4'b1001) begin
      errors++; $display("FAIL rmw_enables got rd1/wr1/rd2/wr2=%b expected 1001", {rd[1], wr[1], rd[2], wr[2]});
    end
    checks++;
    if (wds !== 32'h1122_AB44) begin
      errors++; $display("FAIL rmw_writeData got %h expected 1122ab44", wds);
    end
    checks++;
    if (lat != 3 || d !== 32'h0 || e !== 1'b0) begin
      errors++; $display("FAIL rmw_resp got lat=%0d data=%h err=%b expected 3/00000000/0", lat, d, e);
    end
    issue(1'b0, 2'd2, 1'b0, 10'h20, 32'h0, lat, d, e, rd, wr, wds);
    checks++;
    if (d !== 32'h1122_AB44) begin
      errors++; $display("FAIL rmw_readback got %h expected 1122ab44", d);
    end
  endtask

  task automatic test_errors();
    logic       ws [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0] ss [3] = '{2'd2, 2'd1, 2'd3};
    logic [9:0] as [3] = '{10'h02, 10'h03, 10'h10};
    int lat; logic [31:0] d, wds; logic e; logic [7:0] rd, wr;
    for (int unsigned i = 0; i < 3; i++) begin
      issue(ws[i], ss[i], 1'b0, as[i], 32'hFFFF_FFFF, lat, d, e, rd, wr, wds);
      checks++;
      if (e !== 1'b1 || d !== 32'h0 || lat != 2) begin
        errors++; $display("FAIL error_%0d got err=%b data=%h lat=%0d expected 1/00000000/2", i, e, d, lat);
      end
      checks++;
      if (rd !== 8'h0 || wr !== 8'h0) begin
        errors++; $display("FAIL error_enables_%0d got rd=%b wr=%b expected none", i, rd, wr);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first = 0, second = 0;
    logic [31:0] d1 = 'x, d2 = 'x;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 10'h40; req_wdata = 32'hDEAD_BEEF;
    @(posedge clock);
    #1 req_write = 1'b0; req_wdata = 32'h0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clock);
      if (resp_valid) begin
        if (first == 0) begin
          first = c; d1 = resp_data;
          @(posedge clock);
          #1 req_valid = 1'b0;
        end else begin
          second = c; d2 = resp_data;
          break;
        end
      end
    end
    req_valid = 1'b0;
    refMem[16] = 32'hDEAD_BEEF;
    checks++;
    if (first != 2 || d1 !== 32'h0) begin
      errors++; $display("FAIL b2b_store got at=%0d data=%h expected 2/00000000", first, d1);
    end
    checks++;
    if (second != 4 || d2 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL b2b_load got at=%0d data=%h expected 4/deadbeef", second, d2);
    end
  endtask

  task automatic test_reset_write();
    logic sawResp = 1'b0;
    setWord(12, 32'hCAFE_F00D);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_addr = 10'h32; req_wdata = 32'h1234;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (mem_writeEnable !== 1'b1) begin
      errors++; $display("FAIL rst_write_phase got writeEnable=%b expected 1", mem_writeEnable);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_writeEnable !== 1'b0 || mem_readEnable !== 1'b0) begin
      errors++; $display("FAIL rst_drop got wr=%b rd=%b expected 0/0", mem_writeEnable, mem_readEnable);
    end
    repeat (3) begin
      @(negedge clock);
      if (resp_valid) sawResp = 1'b1;
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (resp_valid) sawResp = 1'b1;
    end
    checks++;
    if (sawResp !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_after got sawResp=%b ready=%b expected 0/1", sawResp, req_ready);
    end
    checks++;
    if (bram[12] !== refMem[12]) begin
      errors++; $display("FAIL rst_word got %h expected %h", bram[12], refMem[12]);
    end
  endtask

  task automatic test_random();
    int lat, expLat, bad = 0;
    logic [31:0] d, wds, wd, expD; logic e, w, u, expE; logic [1:0] sz; logic [9:0] a;
    logic [7:0] rd, wr;
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3)); a = 10'($urandom_range(0, 63)); wd = $urandom;
      expE = refErr(sz, a);
      expD = (expE || w) ? 32'h0 : refLoad(refMem[a[9:2]], a, sz, u);
      expLat = (!expE && w && sz != 2'd2) ? 3 : 2;
      if (!expE && w) refMem[a[9:2]] = refStore(refMem[a[9:2]], a, sz, wd);
      issue(w, sz, u, a, wd, lat, d, e, rd, wr, wds);
      checks++;
      if (d !== expD || e !== expE || lat != expLat) begin
        errors++;
        $display("FAIL rand_%0d w=%b sz=%0d a=%h got data=%h err=%b lat=%0d expected %h/%b/%0d",
                 n, w, sz, a, d, e, lat, expD, expE, expLat);
      end
    end
    for (int unsigned i = 0; i < 256; i++) if (bram[i] !== refMem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rand_memory got %0d differing words expected 0", bad);
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < 256; i++) setWord(i, $urandom);
    test_reset();
    test_loads();
    test_subword_store();
    test_errors();
    test_back_to_back();
    test_reset_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
